// File: rtl/rr_arb4_ctrl_if.sv
// Handshake bundle between the requesting units and the rr_arb4_ctrl arbiter.
// The release line is called rel because release is a reserved word.
interface rr_arb4_ctrl_if;
  logic [3:0] req;      // request lines, one per requester
  logic       en;       // arbitration enable, gates new grants only
  logic       rel;      // current owner finished, meaningful only while busy
  logic [3:0] gnt;      // registered one-hot grant or all zeros
  logic [1:0] owner;    // current / last owner index
  logic [1:0] ptr;      // highest-priority index for the next arbitration
  logic       busy;     // a grant is held
  logic       req_up;   // OR of req toward the upstream tree
  logic       timeout;  // one-cycle pulse when the hold limit revokes a grant

  modport master (
    output req, en, rel,
    input  gnt, owner, ptr, busy, req_up, timeout
  );

  modport slave (
    input  req, en, rel,
    output gnt, owner, ptr, busy, req_up, timeout
  );
endinterface

// File: rtl/rr_arb4_ctrl.sv
// rr_arb4_ctrl: four-requester round-robin arbiter with a registered one-hot
// grant held until the owner releases or withdraws. Priority rotates to
// owner+1 on every grant exit, so no requester starves.
// Optional feature macro ARB_HOLD_TIMEOUT_EN: when defined, a grant is revoked
// after MAX_HOLD consecutive cycles and timeout pulses for one cycle.
module rr_arb4_ctrl #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic          clock,
  input  logic          reset,
  rr_arb4_ctrl_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic       timeout_q, timeout_d;
  logic       win_vld;
  logic [1:0] win_idx;
  logic       hold_hit;

`ifdef ARB_HOLD_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  assign hold_hit = (hold_q == 8'(MAX_HOLD - 1));
`else
  assign hold_hit = 1'b0;
`endif

  // Cyclic search ptr, ptr+1, ptr+2, ptr+3; descending loop lets the nearest hit win
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[ptr_q + 2'(k)]) begin
        win_vld = 1'b1;
        win_idx = ptr_q + 2'(k);
      end
    end
  end

  // Next-state logic: issue grant from IDLE, exit GRANT on release/withdraw/hold limit
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.en && win_vld) begin
          state_d = GRANT;
          owner_d = win_idx;
          gnt_d   = 4'b0001 << win_idx;
`ifdef ARB_HOLD_TIMEOUT_EN
          hold_d  = 8'd0;
`endif
        end
      end
      GRANT: begin
        // release and withdraw together still count as one exit
        if (bus.rel || !bus.req[owner_q]) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          ptr_d   = owner_q + 2'd1;
        end else if (hold_hit) begin
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          ptr_d     = owner_q + 2'd1;
          timeout_d = 1'b1;
        end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
          hold_d = hold_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      owner_q   <= 2'd0;
      ptr_q     <= 2'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef ARB_HOLD_TIMEOUT_EN
  // Hold counter: cleared on grant entry, counts cycles spent in GRANT
  always_ff @(posedge clock) begin
    if (!reset) hold_q <= 8'd0;
    else        hold_q <= hold_d;
  end
`endif

  assign bus.gnt     = gnt_q;
  assign bus.owner   = owner_q;
  assign bus.ptr     = ptr_q;
  assign bus.busy    = (state_q == GRANT);
  assign bus.timeout = timeout_q;
  assign bus.req_up  = |bus.req;

  a_gnt_onehot: assert property (@(posedge clock) $onehot0(gnt_q));
  a_busy_gnt:   assert property (@(posedge clock) (state_q == GRANT) == (gnt_q != 4'b0000));
  a_max_hold:   assert property (@(posedge clock) (MAX_HOLD >= 2) && (MAX_HOLD <= 255));

endmodule

// File: doc/rr_arb4_ctrl.md
Name: rr_arb4_ctrl

Overview:
Four-requester round-robin arbiter controller for a shared resource. It sequences ownership with a registered one-hot grant, holds the grant until the owner releases it, and rotates priority so no requester starves. It sits between the requesting units and the shared datapath, and replaces the free-running priority-select counter with request-driven rotation.

Parameters:
MAX_HOLD, 16, maximum consecutive grant cycles per ownership; used only when ARB_HOLD_TIMEOUT_EN is defined; legal range 2..255.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset; sampled on rising edge of clock
req  input  4  request lines; req[i] high = requester i wants the resource
en  input  1  arbitration enable; gates new grants only
release  input  1  current owner finished; valid only while busy=1
gnt  output  4  registered one-hot grant, or all zeros
owner  output  2  index of current/last owner
ptr  output  2  highest-priority index for the next arbitration
busy  output  1  high while a grant is held
req_up  output  1  combinational OR of req; drives the upstream tree
timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit

Behaviour:
- Reset (reset=0 at a clock edge): state=IDLE, gnt=0000, owner=0, ptr=0, busy=0, timeout=0, hold counter=0. Reset mid-grant drops gnt at that same edge. No release is needed.
- req_up = |req at all times, including during reset. It is independent of en and state.
- FSM states:
  - IDLE: gnt=0, busy=0.
  - GRANT: gnt is one-hot at owner, busy=1.
- IDLE -> GRANT:
  - Condition: en=1 and req!=0 at a clock edge.
  - Winner: the first i with req[i]=1, searching cyclically ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - At that edge: owner<=winner, gnt<=1<<winner, busy<=1.
  - Latency: request sampled at edge k gives gnt visible after edge k, i.e. one cycle.
- IDLE with en=0 or req=0: stay in IDLE; all outputs unchanged.
- GRANT hold: stay in GRANT while req[owner]=1 and release=0. gnt is stable. en=0 does not revoke an existing grant.
- GRANT -> IDLE:
  - Condition: release=1, or req[owner]=0 (owner withdrew).
  - At that edge: gnt<=0, busy<=0, ptr<=owner+1 (2-bit wrap, 3->0).
  - Mandatory one idle cycle between grants; a new grant is issued no earlier than the following edge.
- Simultaneous release=1 and req[owner]=0: treated as a single release; ptr advances once.
- release while in IDLE: ignored.
- ptr changes only on a GRANT -> IDLE transition.
- owner holds its last value while in IDLE.
- Requests from non-owners during GRANT are not latched. Arbitration re-samples req in IDLE.
- gnt never has more than one bit set. This is an asserted invariant.

Optional Feature:
ARB_HOLD_TIMEOUT_EN
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each cycle in GRANT.
  - If the counter equals MAX_HOLD-1 and the FSM would otherwise remain in GRANT, the grant is revoked at that edge: gnt<=0, busy<=0, ptr<=owner+1, timeout<=1 for exactly one cycle.
  - Max ownership is therefore MAX_HOLD cycles.
  - release takes precedence on the same edge: normal exit, timeout stays 0.
- Not defined: no counter is built; timeout is tied to 0; grants are held indefinitely.

Test Plan:
- Reset release, req=0000, en=1 for 5 cycles -> gnt=0000, busy=0, ptr=0, req_up=0 throughout.
- req=1010, en=1, ptr=0 -> gnt=0010 one cycle later, owner=1. Then release pulse -> gnt=0000, ptr=2. Next cycle -> gnt=1000, owner=3. Release -> ptr wraps to 0.
- req=1111 held, release pulsed each time busy=1 -> grant order 0,1,2,3,0, with one idle cycle between each grant.
- Owner 2 holds with en=0 -> gnt=0100 is kept. Drop req[2] -> gnt=0000, ptr=3. With en=0, no new grant is issued despite req=0001.
- reset=0 asserted while gnt=0100 -> gnt=0000, ptr=0, owner=0 at that edge. Reset deasserted with req=0100 -> gnt=0100 one cycle later.
- ARB_HOLD_TIMEOUT_EN defined, MAX_HOLD=4, req=0001 held, no release:
  - gnt=0001 for exactly 4 cycles, then gnt=0000 with timeout=1 for one cycle, ptr=1.
  - Next grant to requester 0 follows after the idle cycle.
  - Release on the 4th cycle -> timeout stays 0.
